// File: rtl/axis_frame_chk.sv
// rtl/axis_frame_chk.sv - AXI-Stream video frame structure and ramp-data checker
module axis_frame_chk #(
    parameter int H_PIX    = 16,
    parameter int V_LINES  = 8,
    parameter int THROTTLE = 1
) (
    input  logic        m_axis_aclk,
    input  logic        m_axis_aresetn,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tuser,
    input  logic        s_axis_tlast,
    input  logic        en,
    input  logic        clr_err,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt,
    output logic        err_flag,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        ACTIVE   = 2'd2
    } state_t;

    localparam logic [11:0] PIX_LAST  = 12'(H_PIX - 1);
    localparam logic [11:0] LINE_LAST = 12'(V_LINES - 1);

    state_t      state_q, state_d;
    logic [11:0] pix_q, pix_d;
    logic [11:0] line_q, line_d;
    logic [31:0] exp_q, exp_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        err_flag_q, err_flag_d;
    logic        frame_done_q, frame_done_d;
    logic        tready_q, tready_d;
    logic [7:0]  lfsr_q, lfsr_d;

    logic        beat;
    logic        err_ev;
    logic        at_pix_last;
    logic        at_line_last;
    logic        sof_err;
    logic        data_err;
    logic        last_err;

    // Next-state, position tracking, error accounting and registered tready
    always_comb begin
        state_d      = state_q;
        pix_d        = pix_q;
        line_d       = line_q;
        exp_d        = exp_q;
        frame_cnt_d  = frame_cnt_q;
        err_cnt_d    = err_cnt_q;
        err_flag_d   = err_flag_q;
        frame_done_d = 1'b0;
        err_ev       = 1'b0;

        // Beats handshaken while en is low are dropped unchecked
        beat         = s_axis_tvalid & tready_q & en;
        at_pix_last  = (pix_q == PIX_LAST);
        at_line_last = (line_q == LINE_LAST);
        data_err     = (s_axis_tdata != exp_q);
        sof_err      = s_axis_tuser & ((pix_q != 12'd0) | (line_q != 12'd0));
        last_err     = (s_axis_tlast != at_pix_last);

        // x^8+x^6+x^5+x^4+1, shifting towards the MSB
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

        if (!en) begin
            state_d = IDLE;
            pix_d   = 12'd0;
            line_d  = 12'd0;
        end else begin
            case (state_q)
                IDLE: state_d = WAIT_SOF;
                WAIT_SOF: begin
                    if (beat && s_axis_tuser) begin
                        state_d = ACTIVE;
                        exp_d   = s_axis_tdata + 32'd1;
                        pix_d   = 12'd1;
                        line_d  = 12'd0;
                    end
                end
                ACTIVE: begin
                    if (beat) begin
                        err_ev = data_err | sof_err | last_err;
                        exp_d  = s_axis_tdata + 32'd1;
                        if (sof_err) begin
                            // Restart: this beat becomes pixel 0 of line 0
                            pix_d  = 12'd1;
                            line_d = 12'd0;
                        end else if (at_pix_last && at_line_last) begin
                            state_d      = WAIT_SOF;
                            pix_d        = 12'd0;
                            line_d       = 12'd0;
                            frame_cnt_d  = frame_cnt_q + 16'd1;
                            frame_done_d = 1'b1;
                        end else if (at_pix_last || s_axis_tlast) begin
                            pix_d  = 12'd0;
                            line_d = at_line_last ? 12'd0 : line_q + 12'd1;
                        end else begin
                            pix_d = pix_q + 12'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A new error event takes precedence over a coincident clear
        if (err_ev) begin
            err_flag_d = 1'b1;
            if (clr_err) begin
                err_cnt_d = 16'd1;
            end else if (err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end else if (clr_err) begin
            err_cnt_d  = 16'd0;
            err_flag_d = 1'b0;
        end

        tready_d = (state_d != IDLE) && ((THROTTLE == 0) || (lfsr_d[1:0] != 2'b00));
    end

    // State and status registers with asynchronous reset
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            state_q      <= IDLE;
            pix_q        <= 12'd0;
            line_q       <= 12'd0;
            exp_q        <= 32'd0;
            frame_cnt_q  <= 16'd0;
            err_cnt_q    <= 16'd0;
            err_flag_q   <= 1'b0;
            frame_done_q <= 1'b0;
            tready_q     <= 1'b0;
            lfsr_q       <= 8'h01;
        end else begin
            state_q      <= state_d;
            pix_q        <= pix_d;
            line_q       <= line_d;
            exp_q        <= exp_d;
            frame_cnt_q  <= frame_cnt_d;
            err_cnt_q    <= err_cnt_d;
            err_flag_q   <= err_flag_d;
            frame_done_q <= frame_done_d;
            tready_q     <= tready_d;
            lfsr_q       <= lfsr_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign frame_done    = frame_done_q;
    assign frame_cnt     = frame_cnt_q;
    assign err_cnt       = err_cnt_q;
    assign err_flag      = err_flag_q;
    assign busy          = (state_q == ACTIVE);

endmodule
